// File: rtl/qspi_arbiter.sv
// qspi_arbiter: round-robin sharing of one qspi_manager among NUM_REQ requesters.
// Tracks the start/busy/idle handshake and aborts hung transfers with a watchdog.
module qspi_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int CMD_W          = 8,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CLKS   = 4096,
    parameter int BUSY_WAIT_CLKS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*CMD_W-1:0]    req_cmd,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_timeout,
    output logic [CMD_W-1:0]            mgr_cmd,
    output logic [ADDR_W-1:0]           mgr_addr,
    output logic [DATA_W-1:0]           mgr_wdata,
    output logic                        mgr_start,
    input  logic [DATA_W-1:0]           mgr_rdata,
    input  logic                        mgr_idle,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

    localparam int GW   = $clog2(NUM_REQ);
    localparam int WD_W = $clog2(TIMEOUT_CLKS + 1);
    localparam int BW_W = $clog2(BUSY_WAIT_CLKS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESPOND
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [GW-1:0]      r_grant;
    logic [GW-1:0]      w_idx;
    logic [GW-1:0]      w_win;
    logic               w_found;
    logic               w_accept;
    logic               w_busy_hit;
    logic               w_wd_hit;
    logic [WD_W-1:0]    r_wd_cnt;
    logic [BW_W-1:0]    r_busy_cnt;
    logic [CMD_W-1:0]   r_cmd;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_timeout;
    logic [NUM_REQ-1:0] w_win_oh;
    logic [NUM_REQ-1:0] w_gnt_oh;

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_grant;
        w_idx   = r_grant;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = GW'((int'(r_grant) + k) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_accept   = (r_state == S_IDLE) && w_found && mgr_idle && !reset;
    assign w_win_oh   = NUM_REQ'(1) << w_win;
    assign w_gnt_oh   = NUM_REQ'(1) << r_grant;
    assign w_busy_hit = (r_busy_cnt == BW_W'(BUSY_WAIT_CLKS - 1));
    // Expires so that RESPOND lands TIMEOUT_CLKS clocks after ISSUE.
    assign w_wd_hit   = (r_wd_cnt == WD_W'(TIMEOUT_CLKS - 2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!mgr_idle) begin
                    w_next = S_WAIT_DONE;
                end else if (w_busy_hit) begin
                    w_next = S_RESPOND;
                end
            end
            S_WAIT_DONE: begin
                if (mgr_idle || w_wd_hit) begin
                    w_next = S_RESPOND;
                end
            end
            S_RESPOND: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant    <= GW'(NUM_REQ - 1);
            r_cmd      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_timeout  <= 1'b0;
            r_wd_cnt   <= '0;
            r_busy_cnt <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_grant <= w_win;
                        r_cmd   <= req_cmd[int'(w_win)*CMD_W +: CMD_W];
                        r_addr  <= req_addr[int'(w_win)*ADDR_W +: ADDR_W];
                        r_wdata <= req_wdata[int'(w_win)*DATA_W +: DATA_W];
                    end
                end
                S_ISSUE: begin
                    r_wd_cnt   <= '0;
                    r_busy_cnt <= '0;
                end
                S_WAIT_BUSY: begin
                    r_wd_cnt   <= r_wd_cnt + 1'b1;
                    r_busy_cnt <= r_busy_cnt + 1'b1;
                    // Manager never went busy: an instant transfer.
                    if (mgr_idle && w_busy_hit) begin
                        r_rdata   <= mgr_rdata;
                        r_timeout <= 1'b0;
                    end
                end
                S_WAIT_DONE: begin
                    r_wd_cnt <= r_wd_cnt + 1'b1;
                    if (mgr_idle) begin
                        r_rdata   <= mgr_rdata;
                        r_timeout <= 1'b0;
                    end else if (w_wd_hit) begin
                        r_rdata   <= '0;
                        r_timeout <= 1'b1;
                    end
                end
                S_RESPOND: begin
                    r_timeout <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready   = w_accept ? w_win_oh : '0;
    assign rsp_valid   = (r_state == S_RESPOND) ? w_gnt_oh : '0;
    assign rsp_rdata   = r_rdata;
    assign rsp_timeout = r_timeout;
    assign mgr_cmd     = r_cmd;
    assign mgr_addr    = r_addr;
    assign mgr_wdata   = r_wdata;
    assign mgr_start   = (r_state == S_ISSUE);
    assign busy        = (r_state != S_IDLE);
    assign grant_id    = r_grant;

endmodule

// File: tb/tb_qspi_arbiter.sv
// tb_qspi_arbiter: directed bench with a behavioural qspi_manager model.
// Stimulus queues expected grants/responses; a negedge monitor checks them.
`timescale 1ns/1ps
module tb_qspi_arbiter;

    localparam int NR = 4;
    localparam int CW = 8;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int TO = 64;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NR-1:0] req_valid = '0;
    logic [NR-1:0] req_ready;
    logic [NR*CW-1:0] req_cmd = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic [NR-1:0] rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic rsp_timeout;
    logic [CW-1:0] mgr_cmd;
    logic [AW-1:0] mgr_addr;
    logic [DW-1:0] mgr_wdata;
    logic mgr_start;
    logic [DW-1:0] mgr_rdata = '0;
    logic mgr_idle;
    logic busy;
    logic [1:0] grant_id;

    always #5 clk = ~clk;

    qspi_arbiter #(
        .NUM_REQ(NR), .CMD_W(CW), .ADDR_W(AW), .DATA_W(DW),
        .TIMEOUT_CLKS(TO), .BUSY_WAIT_CLKS(BW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .mgr_cmd(mgr_cmd), .mgr_addr(mgr_addr), .mgr_wdata(mgr_wdata),
        .mgr_start(mgr_start), .mgr_rdata(mgr_rdata), .mgr_idle(mgr_idle),
        .busy(busy), .grant_id(grant_id)
    );

    typedef struct {
        int id;
        logic [CW-1:0] cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } gnt_t;

    typedef struct {
        int id;
        logic [DW-1:0] rdata;
        logic to;
    } rsp_t;

    gnt_t exp_gnt[$];
    rsp_t exp_rsp[$];

    int checks = 0;
    int failures = 0;
    int gnt_seen = 0;
    int rsp_seen = 0;
    int starts = 0;
    int cyc = 0;
    int t_issue = 0;
    int t_rsp = 0;

    // manager model controls
    logic m_idle = 1'b1;
    logic hold_busy = 1'b0;
    logic hang_mode = 1'b0;
    logic rdata_mode = 1'b0;
    int busy_len = 3;
    logic [DW-1:0] next_rdata = '0;

    assign mgr_idle = m_idle & ~hold_busy;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int get_cnt(input int which);
        if (which == 0) return gnt_seen;
        if (which == 1) return rsp_seen;
        return starts;
    endfunction

    task automatic wait_for(input int which, input int target, input int budget);
        int n = 0;
        while (get_cnt(which) < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk($sformatf("wait_event%0d", which), 64'(get_cnt(which) >= target), 64'd1);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_txn(input int id, input logic [DW-1:0] rdata,
                              input logic to);
        gnt_t g;
        rsp_t r;
        g.id = id;
        g.cmd = req_cmd[id*CW +: CW];
        g.addr = req_addr[id*AW +: AW];
        g.wdata = req_wdata[id*DW +: DW];
        exp_gnt.push_back(g);
        r.id = id;
        r.rdata = rdata;
        r.to = to;
        exp_rsp.push_back(r);
    endtask

    always @(posedge clk) cyc++;

    // Behavioural manager: goes busy the cycle after start.
    always begin
        @(negedge clk);
        if (mgr_start) begin
            mgr_rdata = rdata_mode ? {32'hC0DE_0000, mgr_addr} : next_rdata;
            m_idle = 1'b0;
            if (hang_mode) begin
                while (hang_mode) @(negedge clk);
            end else begin
                repeat (busy_len) @(negedge clk);
            end
            m_idle = 1'b1;
        end
    end

    // Monitor / scoreboard
    gnt_t pend;
    logic have_pend = 1'b0;
    logic outstanding = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            have_pend = 1'b0;
            outstanding = 1'b0;
        end else begin
            if (req_ready != '0) begin
                gnt_seen++;
                chk("grant_while_outstanding", 64'(outstanding), 64'd0);
                if (exp_gnt.size() == 0) begin
                    chk("unexpected_grant", 64'(req_ready), 64'd0);
                end else begin
                    pend = exp_gnt.pop_front();
                    chk("req_ready", 64'(req_ready), 64'(1) << pend.id);
                    have_pend = 1'b1;
                end
                outstanding = 1'b1;
            end
            if (mgr_start) begin
                starts++;
                t_issue = cyc;
                chk("start_has_grant", 64'(have_pend), 64'd1);
                if (have_pend) begin
                    chk("mgr_cmd", 64'(mgr_cmd), 64'(pend.cmd));
                    chk("mgr_addr", 64'(mgr_addr), 64'(pend.addr));
                    chk("mgr_wdata", mgr_wdata, pend.wdata);
                    have_pend = 1'b0;
                end
            end
            if (rsp_valid != '0) begin
                rsp_t r;
                rsp_seen++;
                t_rsp = cyc;
                outstanding = 1'b0;
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    r = exp_rsp.pop_front();
                    chk("rsp_valid", 64'(rsp_valid), 64'(1) << r.id);
                    chk("rsp_rdata", rsp_rdata, r.rdata);
                    chk("rsp_timeout", 64'(rsp_timeout), 64'(r.to));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int s0;
        int g0;
        int d;
        for (int i = 0; i < NR; i++) begin
            req_cmd[i*CW +: CW] = 8'h10 + 8'(i);
            req_addr[i*AW +: AW] = 32'h1000 + 32'(i * 16);
            req_wdata[i*DW +: DW] = {32'h5757_0000 + 32'(i), 32'hA0A0_0000 + 32'(i)};
        end

        // reset state
        tick(3);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mgr_start", 64'(mgr_start), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd3);
        chk("rst_mgr_addr", 64'(mgr_addr), 64'd0);
        chk("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
        reset = 1'b0;
        tick(2);

        // single request from requester 2
        req_cmd[2*CW +: CW] = 8'h0B;
        req_addr[2*AW +: AW] = 32'h100;
        next_rdata = 64'hDEAD_BEEF_0000_0001;
        busy_len = 3;
        s0 = starts;
        expect_txn(2, 64'hDEAD_BEEF_0000_0001, 1'b0);
        req_valid = 4'b0100;
        wait_for(0, gnt_seen + 1, 20);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_for(1, rsp_seen + 1, 40);
        tick(2);
        chk("single_starts", 64'(starts - s0), 64'd1);
        chk("single_grant_id", 64'(grant_id), 64'd2);

        // all four continuously valid from reset: 0,1,2,3,0,1
        rdata_mode = 1'b1;
        req_cmd[2*CW +: CW] = 8'h12;
        req_addr[2*AW +: AW] = 32'h1020;
        reset = 1'b1;
        req_valid = 4'b1111;
        tick(2);
        s0 = starts;
        for (int k = 0; k < 6; k++) begin
            expect_txn(k % 4, {32'hC0DE_0000, 32'h1000 + 32'((k % 4) * 16)}, 1'b0);
        end
        reset = 1'b0;
        wait_for(1, rsp_seen + 6, 200);
        req_valid = '0;
        tick(3);
        chk("rr_starts", 64'(starts - s0), 64'd6);

        // manager not idle at request time
        hold_busy = 1'b1;
        g0 = gnt_seen;
        req_valid = 4'b0010;
        tick(5);
        chk("no_grant_while_mgr_busy", 64'(gnt_seen - g0), 64'd0);
        expect_txn(1, {32'hC0DE_0000, 32'h1010}, 1'b0);
        hold_busy = 1'b0;
        #1;
        chk("grant_on_idle_cycle", 64'(req_ready), 64'b0010);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_for(1, rsp_seen + 1, 40);
        tick(2);

        // hung manager -> watchdog abort, then normal service
        hang_mode = 1'b1;
        expect_txn(3, 64'd0, 1'b1);
        req_valid = 4'b1000;
        wait_for(0, gnt_seen + 1, 20);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_for(1, rsp_seen + 1, 200);
        d = t_rsp - t_issue;
        if (d < 63 || d > 65) begin
            chk("watchdog_latency", 64'(d), 64'd64);
        end else begin
            chk("watchdog_latency_window", 64'(d >= 63 && d <= 65), 64'd1);
        end
        hang_mode = 1'b0;
        tick(3);
        s0 = starts;
        expect_txn(0, {32'hC0DE_0000, 32'h1000}, 1'b0);
        req_valid = 4'b0001;
        wait_for(0, gnt_seen + 1, 20);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_for(1, rsp_seen + 1, 40);
        tick(2);
        chk("after_timeout_starts", 64'(starts - s0), 64'd1);

        // reset during WAIT_DONE
        busy_len = 20;
        s0 = starts;
        begin
            gnt_t g;
            g.id = 2;
            g.cmd = req_cmd[2*CW +: CW];
            g.addr = req_addr[2*AW +: AW];
            g.wdata = req_wdata[2*DW +: DW];
            exp_gnt.push_back(g);
        end
        req_valid = 4'b0100;
        wait_for(0, gnt_seen + 1, 20);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_for(2, s0 + 1, 20);
        tick(4);
        chk("pre_reset_busy", 64'(busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_mgr_cmd", 64'(mgr_cmd), 64'd0);
        chk("arst_mgr_addr", 64'(mgr_addr), 64'd0);
        chk("arst_mgr_wdata", mgr_wdata, 64'd0);
        chk("arst_rsp_rdata", rsp_rdata, 64'd0);
        chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("arst_rsp_timeout", 64'(rsp_timeout), 64'd0);
        chk("arst_mgr_start", 64'(mgr_start), 64'd0);
        chk("arst_grant_id", 64'(grant_id), 64'd3);
        begin
            int n = 0;
            while (!m_idle && n < 60) begin
                @(negedge clk);
                n++;
            end
            chk("model_idle_after_reset", 64'(m_idle), 64'd1);
        end
        busy_len = 3;
        expect_txn(0, {32'hC0DE_0000, 32'h1000}, 1'b0);
        expect_txn(1, {32'hC0DE_0000, 32'h1010}, 1'b0);
        req_valid = 4'b0011;
        tick(1);
        reset = 1'b0;
        wait_for(1, rsp_seen + 2, 60);
        req_valid = '0;
        tick(3);

        // one-cycle pulse on requester 1 while 0 is in service
        busy_len = 10;
        s0 = starts;
        g0 = gnt_seen;
        expect_txn(0, {32'hC0DE_0000, 32'h1000}, 1'b0);
        req_valid = 4'b0001;
        wait_for(0, gnt_seen + 1, 20);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_for(2, s0 + 1, 20);
        tick(2);
        req_valid[1] = 1'b1;
        tick(1);
        req_valid[1] = 1'b0;
        wait_for(1, rsp_seen + 1, 60);
        tick(10);
        chk("pulse_grants", 64'(gnt_seen - g0), 64'd1);
        chk("pulse_starts", 64'(starts - s0), 64'd1);

        chk("gnt_queue_empty", 64'(exp_gnt.size()), 64'd0);
        chk("rsp_queue_empty", 64'(exp_rsp.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qspi_arbiter.md
Name: qspi_arbiter

Overview:
- Shares one qspi_manager front end among NUM_REQ independent requesters (register-access engine, SMEM loader, debug host, ...).
- Accepts one complete transaction (cmd/addr/wdata) per requester and grants requesters round-robin.
- Issues a single-cycle start to the manager, tracks the busy/idle handshake, and returns read data plus a status flag to the granted requester only.
- Includes a watchdog so a hung manager cannot deadlock the requesters.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CMD_W, 8, QSPI command field width.
- ADDR_W, 32, QSPI address field width.
- DATA_W, 64, write/read data width (two 32-bit words for SMEM).
- TIMEOUT_CLKS, 4096, maximum clocks from start to manager idle before abort.
- BUSY_WAIT_CLKS, 4, maximum clocks for manager idle to drop after start.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester transaction request; held until accepted.
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse; fields are sampled on this cycle.
- req_cmd  in  NUM_REQ*CMD_W  flattened commands; requester i occupies slice [i*CMD_W +: CMD_W].
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses.
- req_wdata  in  NUM_REQ*DATA_W  flattened write data.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data; valid while any rsp_valid bit is high.
- rsp_timeout  out  1  set with rsp_valid when the transaction was aborted by the watchdog.
- mgr_cmd  out  CMD_W  command to the manager.
- mgr_addr  out  ADDR_W  address to the manager.
- mgr_wdata  out  DATA_W  write data to the manager.
- mgr_start  out  1  one-cycle start strobe.
- mgr_rdata  in  DATA_W  read data from the manager.
- mgr_idle  in  1  manager idle; high when a new start may be issued.
- busy  out  1  high whenever state != IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current or most recent grant.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state=IDLE; req_ready=0; rsp_valid=0; rsp_timeout=0; mgr_start=0.
  - mgr_cmd/addr/wdata=0; rsp_rdata=0; grant_id=NUM_REQ-1 (so requester 0 wins first); all counters=0.
- Reset mid-transaction aborts the transaction with no rsp_valid; the requester must re-issue.
- States:
  - IDLE: if any req_valid and mgr_idle=1, select the winner by round-robin. The search starts at grant_id+1 and wraps modulo NUM_REQ.
    - Same cycle: latch that requester's fields into mgr_*, pulse req_ready[winner], update grant_id, go to ISSUE.
    - If mgr_idle=0, remain in IDLE and grant nothing.
  - ISSUE: mgr_start=1 for exactly one cycle; clear both counters; go to WAIT_BUSY.
  - WAIT_BUSY: wait for mgr_idle=0, then go to WAIT_DONE.
    - If mgr_idle is still 1 after BUSY_WAIT_CLKS cycles, treat the transaction as complete and go to RESPOND. This covers zero-length or instant transactions.
  - WAIT_DONE: on mgr_idle=1, capture rsp_rdata<=mgr_rdata, set rsp_timeout=0, go to RESPOND.
    - If the watchdog (counting from ISSUE) reaches TIMEOUT_CLKS first: rsp_rdata<=0, rsp_timeout=1, go to RESPOND.
  - RESPOND: rsp_valid[grant_id]=1 for one cycle; return to IDLE.
- Timing and latency:
  - Minimum accept-to-rsp_valid latency is 4 clks plus the manager's busy time.
  - The next grant may occur on the cycle after RESPOND.
- mgr_* fields are held stable from ISSUE through RESPOND.
- req_valid deassertion before acceptance withdraws the request with no side effect. req_valid changes after acceptance are ignored.
- A requester holding req_valid after its acceptance is re-arbitrated as a new transaction. Round-robin guarantees it cannot starve the others.
- Simultaneous requests: exactly one is granted; the others wait.
- rsp_timeout is cleared on the cycle after RESPOND.

Test Plan:
- Single request: req_valid[2]=1, cmd=8'h0B, addr=32'h100; manager returns 64'hDEAD_BEEF_0000_0001 → req_ready=4'b0100, one mgr_start, rsp_valid=4'b0100 with that rdata, rsp_timeout=0.
- All four requesters valid continuously from reset → grant order 0,1,2,3,0,1; each rsp_valid precedes the next req_ready; exactly one mgr_start per grant.
- mgr_idle held 0 at request time → no req_ready until mgr_idle=1, then grant on that cycle.
- Manager goes busy and never returns idle; TIMEOUT_CLKS=64 → rsp_valid at 64 clks after ISSUE (±1), rsp_timeout=1, rdata=0; the next request is serviced normally.
- reset asserted during WAIT_DONE → all outputs 0 asynchronously, no rsp_valid, state=IDLE; after release requester 0 wins first.
- req_valid[1] pulsed for one cycle while requester 0 is in service → request 1 is never accepted; no stray mgr_start.
